// File: rtl/swf_pkg.sv
// Shared constants, FSM encoding and the saturating clamp for the streaming 3x3 window filter.
package swf_pkg;

    localparam logic [1:0] MODE_BOX   = 2'd0;
    localparam logic [1:0] MODE_GAUSS = 2'd1;
    localparam logic [1:0] MODE_SHARP = 2'd2;
    localparam logic [1:0] MODE_PASS  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Saturate a signed intermediate into [0, maxv].
    function automatic logic [31:0] clamp(input logic signed [31:0] v, input logic [31:0] maxv);
        if (v < 0) begin
            return '0;
        end
        if ($unsigned(v) > maxv) begin
            return maxv;
        end
        return $unsigned(v);
    endfunction

endpackage

// File: rtl/swf_line_buffer.sv
// One-line circular delay: o_dout is the pixel written IMG_W writes ago at the current slot.
// The write pointer tracks the column counter, so chained instances give rows r-1 and r-2.
module swf_line_buffer #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_we,
    input  logic [PIX_W-1:0] i_din,
    output logic [PIX_W-1:0] o_dout
);

    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    logic [PIX_W-1:0] r_mem [IMG_W];
    logic [AW-1:0]    r_ptr;

    assign o_dout = r_mem[r_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_we) begin
            r_ptr <= (r_ptr == AW'(IMG_W - 1)) ? '0 : r_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[r_ptr] <= i_din;
        end
    end

endmodule

// File: rtl/stream_window_filter.sv
// Streaming 3x3 window filter (box / Gaussian / sharpen / passthrough) over a raster frame.
// Latency 1 from the completing input to out_valid; a stalled output blocks further input.
module stream_window_filter
    import swf_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_pixel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pixel,
    output logic             busy,
    output logic             frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int SW = PIX_W + 5;

    state_t           r_state, w_next;
    logic [1:0]       r_mode;
    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [PIX_W-1:0] r_win [3][3];
    logic [PIX_W-1:0] w_win [3][3];
    logic [PIX_W-1:0] w_lb0, w_lb1;
    logic             w_accept, w_last, w_emit;
    logic             r_out_valid;
    logic [PIX_W-1:0] r_out_pixel;
    logic [PIX_W-1:0] w_result;
    logic [SW-1:0]    w_corner, w_edge, w_centre, w_box_sum, w_gauss_sum;
    logic signed [SW-1:0] w_sharp;

    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_row == RW'(IMG_H - 1)) && (r_col == CW'(IMG_W - 1));
    assign w_emit    = w_accept && (r_row >= RW'(2)) && (r_col >= CW'(2));
    assign out_valid = r_out_valid;
    assign out_pixel = r_out_pixel;

    swf_line_buffer #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_lb0 (
        .clk    (clk),
        .rst    (rst),
        .i_we   (w_accept),
        .i_din  (in_pixel),
        .o_dout (w_lb0)
    );

    swf_line_buffer #(.PIX_W(PIX_W), .IMG_W(IMG_W)) u_lb1 (
        .clk    (clk),
        .rst    (rst),
        .i_we   (w_accept),
        .i_din  (w_lb0),
        .o_dout (w_lb1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = RUN;
            RUN:     if (w_accept && w_last) w_next = DRAIN;
            DRAIN:   if (!r_out_valid || out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (r_state)
            RUN: begin
                in_ready = !r_out_valid || out_ready;
                busy     = 1'b1;
            end
            DRAIN: begin
                frame_done = !r_out_valid || out_ready;
                busy       = r_out_valid && !out_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode <= MODE_BOX;
            r_col  <= '0;
            r_row  <= '0;
        end else begin
            if (r_state == IDLE && start) begin
                r_mode <= mode;
            end
            if (w_accept) begin
                if (r_col == CW'(IMG_W - 1)) begin
                    r_col <= '0;
                    r_row <= (r_row == RW'(IMG_H - 1)) ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    // Window rows: 0 = line r-2, 1 = line r-1, 2 = current line; column 2 is the newest.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_win[i][0] = r_win[i][1];
            w_win[i][1] = r_win[i][2];
        end
        w_win[0][2] = w_lb1;
        w_win[1][2] = w_lb0;
        w_win[2][2] = in_pixel;
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_win <= w_win;
        end
    end

    assign w_corner    = SW'(w_win[0][0]) + SW'(w_win[0][2]) + SW'(w_win[2][0]) + SW'(w_win[2][2]);
    assign w_edge      = SW'(w_win[0][1]) + SW'(w_win[1][0]) + SW'(w_win[1][2]) + SW'(w_win[2][1]);
    assign w_centre    = SW'(w_win[1][1]);
    assign w_box_sum   = w_corner + w_edge + w_centre;
    assign w_gauss_sum = w_corner + (w_edge << 1) + (w_centre << 2);
    assign w_sharp     = $signed((w_centre << 2) + w_centre - w_edge);

    always_comb begin
        w_result = w_win[1][1];
        case (r_mode)
            MODE_BOX:   w_result = PIX_W'(w_box_sum / SW'(9));
            MODE_GAUSS: w_result = PIX_W'(w_gauss_sum >> 4);
            MODE_SHARP: w_result = PIX_W'(clamp(32'(w_sharp), 32'((1 << PIX_W) - 1)));
            default:    w_result = w_win[1][1];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_pixel <= '0;
        end else if (w_emit) begin
            r_out_valid <= 1'b1;
            r_out_pixel <= w_result;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_window_filter.sv
// Randomised frames on a 4x4 filter, scored against a per-window arithmetic model.
module tb_stream_window_filter;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;
    localparam int BUDGET = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_pixel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_pixel;
    logic       busy;
    logic       frame_done;

    int frame [N];
    int exp_q [$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stream_window_filter #(.PIX_W(8), .IMG_W(W), .IMG_H(H)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pixel  (out_pixel),
        .busy       (busy),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input int got, input int expv);
        n_cmp++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, expv);
        end
    endtask

    function automatic int px(input int r, input int c);
        return frame[r * W + c];
    endfunction

    // Expected outputs for every interior centre, in raster order.
    task automatic build_expected(input int md);
        int s, g, v, cc;
        exp_q.delete();
        for (int r = 1; r < H - 1; r++) begin
            for (int c = 1; c < W - 1; c++) begin
                s = 0;
                g = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        s += px(r + dr, c + dc);
                        g += px(r + dr, c + dc) * (2 - dr * dr) * (2 - dc * dc);
                    end
                end
                cc = px(r, c);
                case (md)
                    0: v = s / 9;
                    1: v = g / 16;
                    2: begin
                        v = 5 * cc - px(r - 1, c) - px(r + 1, c) - px(r, c - 1) - px(r, c + 1);
                        if (v < 0) v = 0;
                        if (v > 255) v = 255;
                    end
                    default: v = cc;
                endcase
                exp_q.push_back(v);
            end
        end
    endtask

    // bp: 0 = always ready, 1 = random valid/ready, 2 = ready held low 5 cycles.
    // abort_after >= 0: assert rst once that many pixels have been accepted.
    task automatic run_frame(input int md, input int bp, input int abort_after);
        int  idx = 0, cyc = 0, outs = 0, dones = 0, hold_pix = 0, bp_left;
        bit  hold = 0;
        build_expected(md);
        bp_left = (bp == 2) ? 5 : 0;

        @(negedge clk);
        in_valid  = 1'b1;
        in_pixel  = 8'hAA;
        out_ready = 1'b1;
        #1;
        check("idle_in_ready", in_ready, 0);
        mode  = 2'(md);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        while (cyc < BUDGET) begin
            in_valid = (idx < N) && (bp != 1 || $urandom_range(0, 3) != 0);
            in_pixel = (idx < N) ? 8'(frame[idx]) : 8'h00;
            if (bp == 2 && out_valid && bp_left > 0) begin
                out_ready = 1'b0;
                bp_left--;
            end else begin
                out_ready = (bp == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            mode  = 2'($urandom);
            start = (cyc == 3);
            #1;
            if (cyc == 0) check("busy_running", busy, 1);
            if (hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_pixel", out_pixel, hold_pix);
            end
            hold = out_valid && !out_ready;
            if (hold) begin
                hold_pix = out_pixel;
                check("hold_in_ready", in_ready, 0);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) check("out_pixel", out_pixel, exp_q.pop_front());
                outs++;
            end
            if (frame_done) begin
                dones++;
                check("busy_at_done", busy, 0);
            end
            if (in_valid && in_ready) idx++;
            if (dones > 0) break;
            if (abort_after >= 0 && idx >= abort_after) begin
                @(posedge clk);
                #2;
                rst = 1'b1;
                #1;
                check("abort_out_valid", out_valid, 0);
                check("abort_out_pixel", out_pixel, 0);
                check("abort_busy", busy, 0);
                check("abort_in_ready", in_ready, 0);
                check("abort_done", frame_done, 0);
                @(negedge clk);
                rst      = 1'b0;
                in_valid = 1'b0;
                start    = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    #1;
                    check("abort_no_done", frame_done, 0);
                end
                return;
            end
            @(negedge clk);
            cyc++;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        check("frame_in_budget", int'(cyc < BUDGET), 1);
        check("in_count", idx, N);
        check("out_count", outs, (W - 2) * (H - 2));
        check("done_count", dones, 1);
        @(negedge clk);
        #1;
        check("done_cleared", frame_done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        mode      = 2'd0;
        in_valid  = 1'b0;
        in_pixel  = 8'h00;
        out_ready = 1'b0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pixel", out_pixel, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_frame_done", frame_done, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < N; i++) frame[i] = 100;
            run_frame(m, 0, -1);
        end

        for (int i = 0; i < N; i++) frame[i] = 4 * (i / W) + (i % W);
        run_frame(0, 0, -1);
        run_frame(3, 0, -1);

        for (int i = 0; i < N; i++) frame[i] = 0;
        frame[W + 1] = 255;
        run_frame(2, 0, -1);
        for (int i = 0; i < N; i++) frame[i] = 255;
        frame[W + 1] = 0;
        run_frame(2, 0, -1);
        for (int i = 0; i < N; i++) frame[i] = 0;
        frame[W + 1] = 16;
        run_frame(1, 0, -1);

        for (int i = 0; i < N; i++) frame[i] = $urandom_range(0, 255);
        run_frame(0, 2, -1);

        for (int f = 0; f < 20; f++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0:       frame[i] = 0;
                    1:       frame[i] = 255;
                    default: frame[i] = $urandom_range(0, 255);
                endcase
            end
            run_frame($urandom_range(0, 3), 1, -1);
        end

        for (int i = 0; i < N; i++) frame[i] = $urandom_range(0, 255);
        run_frame(1, 0, 7);
        run_frame(2, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
